memory_bus_responder: RTL and testbench

MEMORY_BUS_RESPONDER -- requirements
Module: memory_bus_responder

---
 rtl/memory_bus_pkg.sv | 20 ++
 rtl/memory_bus_sram.sv | 36 +++
 rtl/memory_bus_responder.sv | 150 +++++++++++++++
 tb/tb_memory_bus_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_bus_pkg.sv
// memory_bus_pkg
// Shared types and constants for the memory bus responder and its storage.
//   bus_state_e : responder FSM state encoding
//   DATA_W      : bus data width (bits)
//   MASK_W      : byte-enable width (one bit per data byte)
//   BYTE_W      : bits covered by one byte-enable bit
package memory_bus_pkg;

  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RESPOND = 2'd3
  } bus_state_e;

endpackage

// File: rtl/memory_bus_sram.sv
// memory_bus_sram
// Single-port synchronous-read RAM with per-byte write enables, written so
// synthesis maps it onto block RAM. Contents are never reset.
// Ports:
//   clock : rising-edge clock
//   en    : port enable; a read (and any enabled byte writes) happen on the edge
//   we    : byte write enables, bit i covers wdata[8i+7:8i]
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (read-before-write), updated only when en=1
module memory_bus_sram
  import memory_bus_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              en,
  input  logic [MASK_W-1:0] we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < MASK_W; i++) begin
        if (we[i]) mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/memory_bus_responder.sv
// memory_bus_responder
// Bus target that accepts one request at a time, optionally stalls for
// WAIT_STATES cycles, performs a single access to an internal RAM and answers
// with a one-cycle ready pulse.
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset
//   valid     : request strobe, sampled only in IDLE
//   write     : 1 = write, 0 = read
//   address   : word address (ADDRESS_SIZE bits)
//   dataWrite : write data
//   writeMask : byte enables for writes
//   ready     : one-cycle completion pulse
//   dataRead  : read data, valid with ready; holds the last read value otherwise
//   error     : out-of-range flag, valid with ready
// Build option: define MEMORY_BUS_RESPONDER_RANGE_CHECK_EN to flag addresses
// >= MEM_WORDS (write suppressed, read returns 0). Without it addresses wrap.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | waiting for valid; request fields latched on accept
// ST_WAIT    | stalling until the wait counter reaches zero
// ST_ACCESS  | RAM enabled for exactly one read or write
// ST_RESPOND | ready pulsed; read data presented from the RAM
module memory_bus_responder
  import memory_bus_pkg::*;
#(
  parameter int ADDRESS_SIZE = 15,
  parameter int MEM_WORDS    = 4096,
  parameter int WAIT_STATES  = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    valid,
  input  logic                    write,
  input  logic [ADDRESS_SIZE-1:0] address,
  input  logic [DATA_W-1:0]       dataWrite,
  input  logic [MASK_W-1:0]       writeMask,
  output logic                    ready,
  output logic [DATA_W-1:0]       dataRead,
  output logic                    error
);

  localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  bus_state_e state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic write_q;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] mask_q;
  logic [DATA_W-1:0] hold_q;
  logic accept;
  logic mem_en;
  logic range_err;
  logic [MASK_W-1:0] mem_we;
  logic [DATA_W-1:0] mem_rdata;

`ifdef MEMORY_BUS_RESPONDER_RANGE_CHECK_EN
  localparam logic [ADDRESS_SIZE:0] MEM_LIMIT = (ADDRESS_SIZE + 1)'(MEM_WORDS);
  assign range_err = ({1'b0, addr_q} >= MEM_LIMIT);
`else
  // Upper address bits only matter for the range check; without it they wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q;
  assign range_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (accept) begin
        write_q <= write;
        addr_q  <= address;
        wdata_q <= dataWrite;
        mask_q  <= writeMask;
      end
      // Capture what is on the bus during RESPOND so dataRead keeps showing
      // the last read result through later writes and idle cycles.
      if (state_q == ST_RESPOND) hold_q <= dataRead;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    accept     = 1'b0;
    mem_en     = 1'b0;
    ready      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = ST_ACCESS;
        else wait_cnt_d = wait_cnt_q - 4'd1;
      end
      ST_ACCESS: begin
        mem_en  = 1'b1;
        state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        ready   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dataRead = hold_q;
    if (ready && !write_q) dataRead = range_err ? '0 : mem_rdata;
  end

  assign error  = ready && range_err;
  // The enable is decoded from the state register, so an asynchronous reset
  // during ACCESS removes it before the edge and no byte is written.
  assign mem_we = (mem_en && write_q && !range_err) ? mask_q : '0;

  memory_bus_sram #(
    .DEPTH (MEM_WORDS),
    .ADDR_W(MEM_AW)
  ) u_sram (
    .clock(clock),
    .en   (mem_en),
    .we   (mem_we),
    .addr (addr_q[MEM_AW-1:0]),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_memory_bus_responder.sv
module tb_memory_bus_responder;

`ifdef MEMORY_BUS_RESPONDER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clock;
  logic        reset     [2];
  logic        valid     [2];
  logic        write     [2];
  logic [14:0] address   [2];
  logic [31:0] dataWrite [2];
  logic [3:0]  writeMask [2];
  logic        ready     [2];
  logic [31:0] dataRead  [2];
  logic        error     [2];

  int checks = 0;
  int errors = 0;

  // Reference model: 8 words at 0x40..0x47 per instance, plus last read value.
  logic [31:0] mem_m   [2][8];
  logic [31:0] last_rd [2];

  memory_bus_responder #(.ADDRESS_SIZE(15), .MEM_WORDS(4096), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset[0]), .valid(valid[0]), .write(write[0]),
    .address(address[0]), .dataWrite(dataWrite[0]), .writeMask(writeMask[0]),
    .ready(ready[0]), .dataRead(dataRead[0]), .error(error[0]));

  memory_bus_responder #(.ADDRESS_SIZE(15), .MEM_WORDS(4096), .WAIT_STATES(3)) dut3 (
    .clock(clock), .reset(reset[1]), .valid(valid[1]), .write(write[1]),
    .address(address[1]), .dataWrite(dataWrite[1]), .writeMask(writeMask[1]),
    .ready(ready[1]), .dataRead(dataRead[1]), .error(error[1]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic int ws(input int inst);
    return (inst == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // One transaction. lat counts edges from acceptance to the edge at which
  // ready is first sampled high (expected WAIT_STATES+2). Inputs are scrambled
  // right after acceptance to show they are not used any more.
  task automatic txn(input int inst, input bit wr, input logic [14:0] a,
                     input logic [31:0] d, input logic [3:0] m,
                     output logic [31:0] rd, output logic er, output int lat);
    lat = -1;
    rd  = '0;
    er  = 1'b0;
    @(negedge clock);
    valid[inst] = 1'b1; write[inst] = wr; address[inst] = a;
    dataWrite[inst] = d; writeMask[inst] = m;
    @(posedge clock);
    @(negedge clock);
    valid[inst] = 1'b0; write[inst] = ~wr; address[inst] = 15'($urandom);
    dataWrite[inst] = $urandom; writeMask[inst] = 4'($urandom);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      #1;
      if (ready[inst]) begin
        lat = c + 1;
        rd  = dataRead[inst];
        er  = error[inst];
        break;
      end
    end
    if (lat < 0) begin
      chk("ready_timeout", 32'(ready[inst]), 32'd1);
    end else begin
      @(posedge clock);
      #1;
      chk("ready_one_cycle", 32'(ready[inst]), 32'd0);
    end
  endtask

  task automatic rand_txn(input int inst, input bit wr, input int j, input int k,
                          input logic [31:0] d, input logic [3:0] m);
    logic [14:0] a;
    logic oor;
    logic [31:0] erd, rd;
    logic er;
    int lat;
    a   = 15'(k * 4096 + 64 + j);
    oor = RC && (k != 0);
    erd = wr ? last_rd[inst] : (oor ? 32'h0 : mem_m[inst][j]);
    txn(inst, wr, a, d, m, rd, er, lat);
    chk("rand_latency", 32'(lat), 32'(ws(inst) + 2));
    chk("rand_data", rd, erd);
    chk("rand_error", 32'(er), 32'(oor));
    if (!wr) last_rd[inst] = erd;
    else if (!oor) begin
      for (int b = 0; b < 4; b++)
        if (m[b]) mem_m[inst][j][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  typedef struct {
    bit          wr;
    logic [14:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [31:0] rd;
    logic er;
    int lat;
    int pulses[$];
    int rcount;

    tbl[0]  = '{1'b1, 15'h0010, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 15'h0010, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 15'h0020, 32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b1, 15'h0020, 32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0};
    tbl[4]  = '{1'b0, 15'h0020, 32'h00000000, 4'h0, 32'h11BB33DD, 1'b0};
    tbl[5]  = '{1'b1, 15'h0010, 32'h00000000, 4'h0, 32'h11BB33DD, 1'b0};
    tbl[6]  = '{1'b0, 15'h0010, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0};
    tbl[7]  = '{1'b1, 15'h0005, 32'h12345678, 4'hF, 32'hDEADBEEF, 1'b0};
    tbl[8]  = '{1'b1, 15'h1005, 32'hCAFEF00D, 4'hF, 32'hDEADBEEF, RC};
    tbl[9]  = '{1'b0, 15'h0005, 32'h00000000, 4'h0, RC ? 32'h12345678 : 32'hCAFEF00D, 1'b0};
    tbl[10] = '{1'b0, 15'h1005, 32'h00000000, 4'h0, RC ? 32'h00000000 : 32'hCAFEF00D, RC};

    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; valid[i] = 1'b0; write[i] = 1'b0; address[i] = '0;
      dataWrite[i] = '0; writeMask[i] = '0; last_rd[i] = '0;
    end
    #1;
    reset[0] = 1'b0; reset[1] = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", 32'(ready[i]), 32'd0);
      chk("reset_error", 32'(error[i]), 32'd0);
      chk("reset_data", dataRead[i], 32'd0);
    end
    repeat (2) @(negedge clock);
    reset[0] = 1'b1; reset[1] = 1'b1;
    repeat (2) @(negedge clock);

    // Directed vectors on the zero-wait-state instance.
    for (int i = 0; i < 11; i++) begin
      txn(0, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].mask, rd, er, lat);
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp_data);
      chk($sformatf("tbl%0d_error", i), 32'(er), 32'(tbl[i].exp_err));
      if (!tbl[i].wr) last_rd[0] = tbl[i].exp_data;
    end

    // Reset in WAIT discards a write (three wait states).
    txn(1, 1'b1, 15'h0030, 32'h00000000, 4'hF, rd, er, lat);
    chk("rst_pre_latency", 32'(lat), 32'd5);
    @(negedge clock);
    valid[1] = 1'b1; write[1] = 1'b1; address[1] = 15'h0030;
    dataWrite[1] = 32'hFFFFFFFF; writeMask[1] = 4'hF;
    @(posedge clock);
    @(negedge clock);
    valid[1] = 1'b0;
    reset[1] = 1'b0;
    #1;
    chk("rst_wait_ready", 32'(ready[1]), 32'd0);
    chk("rst_wait_data", dataRead[1], 32'd0);
    chk("rst_wait_error", 32'(error[1]), 32'd0);
    @(negedge clock);
    reset[1] = 1'b1;
    last_rd[1] = '0;
    rcount = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock);
      #1;
      if (ready[1]) rcount++;
    end
    chk("rst_no_ready", 32'(rcount), 32'd0);
    txn(1, 1'b0, 15'h0030, 32'h0, 4'h0, rd, er, lat);
    chk("rst_read_back", rd, 32'h00000000);
    chk("rst_read_latency", 32'(lat), 32'd5);

    // Valid held high: a read every WAIT_STATES+3 = 6 cycles.
    @(negedge clock);
    valid[1] = 1'b1; write[1] = 1'b0; address[1] = 15'h0030;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock);
      #1;
      if (ready[1]) begin
        if (pulses.size() == 0) chk("b2b_data", dataRead[1], 32'h0);
        pulses.push_back(c);
      end
    end
    @(negedge clock);
    valid[1] = 1'b0;
    repeat (8) @(negedge clock);
    chk("b2b_count", 32'(pulses.size()), 32'd5);
    if (pulses.size() > 0) chk("b2b_first", 32'(pulses[0]), 32'd4);
    for (int i = 1; i < pulses.size(); i++)
      chk("b2b_spacing", 32'(pulses[i] - pulses[i-1]), 32'd6);

    // Randomized traffic against the model: prefill, then mixed operations.
    for (int inst = 0; inst < 2; inst++)
      for (int j = 0; j < 8; j++)
        rand_txn(inst, 1'b1, j, 0, $urandom, 4'hF);
    for (int n = 0; n < 250; n++) begin
      int inst, j, k;
      inst = (n % 4 == 3) ? 1 : 0;
      j = $urandom_range(0, 7);
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      rand_txn(inst, 1'($urandom_range(0, 1)), j, k, $urandom, 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
